// File: rtl/rv_plic_target_scan.sv
// Per-target PLIC scan stage: walks the sources one per cycle, publishes the
// best eligible ID at the end of each sweep and turns claim/complete into gateway pulses.
module rv_plic_target_scan #(
    parameter int N_SOURCE = 32,
    parameter int PRIO_W   = 3,
    parameter int ID_W     = $clog2(N_SOURCE + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [N_SOURCE-1:0]        ip_i,
    input  logic [N_SOURCE-1:0]        ie_i,
    input  logic [N_SOURCE*PRIO_W-1:0] prio_i,
    input  logic [PRIO_W-1:0]          threshold_i,
    input  logic                       claim_req_i,
    input  logic                       complete_req_i,
    input  logic [ID_W-1:0]            complete_id_i,
    output logic                       irq_o,
    output logic [ID_W-1:0]            irq_id_o,
    output logic [ID_W-1:0]            claim_id_o,
    output logic [N_SOURCE-1:0]        claim_o,
    output logic [N_SOURCE-1:0]        complete_o
);

    localparam int CNT_W = (N_SOURCE > 1) ? $clog2(N_SOURCE) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SOURCE - 1);

    logic [CNT_W-1:0]    r_cnt;
    logic [PRIO_W-1:0]   r_best_prio;
    logic [ID_W-1:0]     r_best_id;

    logic [PRIO_W-1:0]   w_prio [N_SOURCE];
    logic [N_SOURCE-1:0] w_claim_hot;
    logic [N_SOURCE-1:0] w_complete_hot;
    logic [PRIO_W-1:0]   w_cur_prio;
    logic                w_eligible;
    logic                w_take;
    logic [PRIO_W-1:0]   w_next_prio;
    logic [ID_W-1:0]     w_next_id;

    // Per-source decode: priority unpacking and the one-hot0 pulse patterns.
    generate
        for (genvar gi = 0; gi < N_SOURCE; gi++) begin : g_src
            assign w_prio[gi]         = prio_i[gi*PRIO_W +: PRIO_W];
            assign w_claim_hot[gi]    = (irq_id_o == ID_W'(gi + 1));
            assign w_complete_hot[gi] = complete_req_i && (complete_id_i == ID_W'(gi + 1)) && ie_i[gi];
        end
    endgenerate

    assign w_cur_prio  = w_prio[r_cnt];
    assign w_eligible  = ip_i[r_cnt] & ie_i[r_cnt] & (w_cur_prio > threshold_i);
    // Strict compare keeps the earlier (lower) index on priority ties.
    assign w_take      = w_eligible && (w_cur_prio > r_best_prio);
    assign w_next_prio = w_take ? w_cur_prio : r_best_prio;
    assign w_next_id   = w_take ? (ID_W'(r_cnt) + ID_W'(1)) : r_best_id;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt       <= '0;
            r_best_prio <= '0;
            r_best_id   <= '0;
            irq_o       <= 1'b0;
            irq_id_o    <= '0;
            claim_id_o  <= '0;
            claim_o     <= '0;
            complete_o  <= '0;
        end else begin
            complete_o <= w_complete_hot;
            if (claim_req_i) begin
                // Restart the sweep so the claimed source is not re-reported stale.
                claim_id_o  <= irq_id_o;
                claim_o     <= w_claim_hot;
                irq_o       <= 1'b0;
                irq_id_o    <= '0;
                r_cnt       <= '0;
                r_best_prio <= '0;
                r_best_id   <= '0;
            end else begin
                claim_o <= '0;
                if (r_cnt == LAST_CNT) begin
                    irq_id_o    <= w_next_id;
                    irq_o       <= (w_next_id != '0);
                    r_cnt       <= '0;
                    r_best_prio <= '0;
                    r_best_id   <= '0;
                end else begin
                    r_cnt       <= r_cnt + CNT_W'(1);
                    r_best_prio <= w_next_prio;
                    r_best_id   <= w_next_id;
                end
            end
        end
    end

endmodule

// File: tb/tb_rv_plic_target_scan.sv
// Bench for rv_plic_target_scan: sweep-level reference model checked every cycle,
// plus directed scenarios with literal expectations and a randomized phase.
module tb_rv_plic_target_scan;

    localparam int N  = 8;
    localparam int PW = 3;
    localparam int IW = $clog2(N + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    ip, ie;
    logic [N*PW-1:0] prio;
    logic [PW-1:0]   thr;
    logic            claim, complete;
    logic [IW-1:0]   cid;
    logic            irq_o;
    logic [IW-1:0]   irq_id_o, claim_id_o;
    logic [N-1:0]    claim_o, complete_o;

    int tests = 0;
    int fails = 0;

    rv_plic_target_scan #(.N_SOURCE(N), .PRIO_W(PW)) dut (
        .clk_i(clk), .rst_i(rst), .ip_i(ip), .ie_i(ie), .prio_i(prio),
        .threshold_i(thr), .claim_req_i(claim), .complete_req_i(complete),
        .complete_id_i(cid), .irq_o(irq_o), .irq_id_o(irq_id_o),
        .claim_id_o(claim_id_o), .claim_o(claim_o), .complete_o(complete_o)
    );

    always #5 clk = ~clk;

    // Reference model: snapshot each source when the sweep visits it, then
    // pick the winner over the whole snapshot when the sweep ends.
    bit            m_elig [N];
    int            m_prio [N];
    int            m_pos = 0;
    logic          exp_irq = 1'b0;
    logic [IW-1:0] exp_id = '0, exp_cid = '0;
    logic [N-1:0]  exp_claim = '0, exp_comp = '0;

    always @(posedge clk) begin : model
        int p, maxp, win;
        if (rst) begin
            m_pos = 0; exp_irq = 0; exp_id = '0; exp_cid = '0;
            exp_claim = '0; exp_comp = '0;
        end else begin
            p = int'(prio[m_pos*PW +: PW]);
            m_prio[m_pos] = p;
            m_elig[m_pos] = ip[m_pos] && ie[m_pos] && (p > int'(thr));
            exp_claim = '0;
            exp_comp  = '0;
            if (claim) begin
                exp_cid = exp_id;
                if (exp_id != 0) exp_claim = N'(1) << (int'(exp_id) - 1);
                exp_irq = 0; exp_id = '0; m_pos = 0;
            end else if (m_pos == N - 1) begin
                maxp = 0;
                for (int k = 0; k < N; k++)
                    if (m_elig[k] && m_prio[k] > maxp) maxp = m_prio[k];
                win = 0;
                for (int k = N - 1; k >= 0; k--)
                    if (m_elig[k] && m_prio[k] == maxp) win = k + 1;
                exp_id = IW'(win); exp_irq = (win != 0); m_pos = 0;
            end else begin
                m_pos++;
            end
            if (complete && cid >= 1 && int'(cid) <= N && ie[int'(cid) - 1])
                exp_comp = N'(1) << (int'(cid) - 1);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_irq",      32'(irq_o),      32'(exp_irq));
        check("model_irq_id",   32'(irq_id_o),   32'(exp_id));
        check("model_claim_id", 32'(claim_id_o), 32'(exp_cid));
        check("model_claim",    32'(claim_o),    32'(exp_claim));
        check("model_complete", 32'(complete_o), 32'(exp_comp));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_prio(input int k, input int v);
        prio[k*PW +: PW] = PW'(v);
    endtask

    task automatic wait_id(input int id, input string nm);
        bit ok = 0;
        for (int c = 0; c < 2 * N + 4; c++) begin
            @(negedge clk);
            if (int'(irq_id_o) == id && irq_o == (id != 0)) begin
                ok = 1;
                break;
            end
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: irq_id_o=%0d expected %0d within %0d cycles", nm, irq_id_o, id, 2 * N + 4);
        end
    endtask

    // Present claim/complete for one sampling edge, return at the following negedge.
    task automatic pulse(input bit c, input bit p, input int id);
        tick();
        claim = c; complete = p; cid = IW'(id);
        tick();
        claim = 0; complete = 0; cid = '0;
        @(negedge clk);
    endtask

    initial begin : stim
        bit quiet;
        rst = 1; ip = '0; ie = '0; prio = '0; thr = '0;
        claim = 0; complete = 0; cid = '0;
        repeat (3) @(negedge clk);
        check("reset_irq", 32'(irq_o), 0);
        check("reset_id", 32'(irq_id_o), 0);
        check("reset_claim", 32'(claim_o), 0);
        tick(); rst = 0;

        // Basic raise and claim
        ie = 8'hFF; set_prio(3, 2); thr = 1; ip = 8'h08;
        wait_id(4, "raise_id4");
        pulse(1, 0, 0);
        check("claim_id4", 32'(claim_id_o), 4);
        check("claim_hot4", 32'(claim_o), 32'h08);
        check("claim_irq_low", 32'(irq_o), 0);
        @(negedge clk);
        check("claim_one_cycle", 32'(claim_o), 0);
        check("claim_id_hold", 32'(claim_id_o), 4);
        ip = '0;

        // Tie then priority raise
        set_prio(2, 5); set_prio(5, 5); ip = 8'h24;
        wait_id(3, "tie_low_index");
        set_prio(5, 6);
        wait_id(6, "prio_raise");

        // Threshold gating
        ip = 8'h02; set_prio(1, 3); thr = 3;
        wait_id(0, "thr_drop");
        quiet = 1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (irq_o) quiet = 0;
        end
        check("thr_equal_quiet", 32'(quiet), 1);
        thr = 2;
        wait_id(2, "thr_lowered");
        ie[1] = 0;
        wait_id(0, "ie_cleared");

        // Complete filtering
        ie = 8'hFF;
        pulse(0, 1, 6);
        check("complete6", 32'(complete_o), 32'h20);
        @(negedge clk);
        check("complete_one_cycle", 32'(complete_o), 0);
        ie[5] = 0;
        pulse(0, 1, 6);
        check("complete6_disabled", 32'(complete_o), 0);
        ie[5] = 1;
        pulse(0, 1, 0);
        check("complete0", 32'(complete_o), 0);
        pulse(0, 1, 9);
        check("complete9", 32'(complete_o), 0);

        // Claims with nothing pending, simultaneous, back-to-back
        ip = '0;
        wait_id(0, "idle");
        pulse(1, 0, 0);
        check("claim_idle_id", 32'(claim_id_o), 0);
        check("claim_idle_hot", 32'(claim_o), 0);
        prio = '0; set_prio(3, 2); thr = 1; ip = 8'h08;
        wait_id(4, "reraise_id4");
        pulse(1, 1, 2);
        check("simul_claim", 32'(claim_o), 32'h08);
        check("simul_complete", 32'(complete_o), 32'h02);
        wait_id(4, "reraise2_id4");
        tick(); claim = 1;
        tick();
        tick(); claim = 0;
        @(negedge clk);
        check("b2b_claim_id", 32'(claim_id_o), 0);
        check("b2b_claim_hot", 32'(claim_o), 0);

        // Reset in mid-sweep, then exact publish latency
        prio = '0;
        set_prio(0, 1); set_prio(1, 2); set_prio(2, 3); set_prio(3, 4);
        set_prio(4, 5); set_prio(5, 6); set_prio(6, 7); set_prio(7, 3);
        ip = 8'hFF; ie = 8'hFF; thr = 0;
        for (int c = 0; c < 4 * N; c++) begin
            tick();
            if (m_pos == 4) break;
        end
        check("reach_cnt4", 32'(m_pos), 4);
        rst = 1;
        tick(); rst = 0;
        @(negedge clk);
        check("mid_rst_outputs", 32'({irq_o, irq_id_o, claim_id_o, claim_o, complete_o}), 0);
        for (int c = 1; c <= N; c++) begin
            @(negedge clk);
            if (c < N) check("pre_publish_quiet", 32'(irq_o), 0);
            else       check("publish_after_8", 32'({irq_o, irq_id_o}), 32'({1'b1, 4'd7}));
        end

        // Randomized traffic, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            tick();
            if ($urandom_range(3) == 0) ip = N'($urandom);
            if ($urandom_range(15) == 0) ie = N'($urandom) | N'($urandom);
            if ($urandom_range(20) == 0) prio = (N*PW)'($urandom);
            if ($urandom_range(40) == 0) thr = PW'($urandom_range(3));
            claim    = ($urandom_range(11) == 0);
            complete = ($urandom_range(6) == 0);
            cid      = IW'($urandom_range(10));
            rst      = ($urandom_range(300) == 0);
        end
        tick();
        claim = 0; complete = 0; rst = 0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
